// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: frame width and FSM state encoding.
package uart_tx_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the upstream byte source, the serializer and the TX controller.
interface uart_tx_ctrl_if
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] P_DATA;
  logic             P_DATA_VLD;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             ser_done;
  logic             ser_out;
  logic             ser_en;
  logic             ser_data_valid;
  logic             TX_OUT;
  logic             Busy;

  // Environment side: byte source plus serializer.
  modport master (
    output P_DATA, P_DATA_VLD, PAR_EN, PAR_TYP, ser_done, ser_out,
    input  ser_en, ser_data_valid, TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, P_DATA_VLD, PAR_EN, PAR_TYP, ser_done, ser_out,
    output ser_en, ser_data_valid, TX_OUT, Busy
  );

endinterface

// File: rtl/parity_calc.sv
// Parity bit for one frame, captured on the accept strobe so later input changes are ignored.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             accept,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_TYP,
  output logic             parity
);

  // Even parity is the XOR of the data; odd parity is its inverse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= (^P_DATA) ^ PAR_TYP;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing FSM: start bit, 8 serializer data bits, optional parity, stop bit.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  tx_state_e state_q;
  logic      par_en_q;
  logic      parity_q;
  logic      accept;
  logic      tx_mux;

  // Accept is gated by RST so the serializer never loads during reset.
  assign accept = (state_q == StIdle) && bus.P_DATA_VLD && !RST;

  parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity_calc (
    .CLK     (CLK),
    .RST     (RST),
    .accept  (accept),
    .P_DATA  (bus.P_DATA),
    .PAR_TYP (bus.PAR_TYP),
    .parity  (parity_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      par_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StStart;
            par_en_q <= bus.PAR_EN;
          end
        end
        StStart:  state_q <= StData;
        StData: begin
          if (bus.ser_done) begin
            state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: state_q <= StStop;
        StStop:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Line level is selected only from registered sources.
  always_comb begin
    tx_mux = 1'b1;
    case (state_q)
      StStart:  tx_mux = 1'b0;
      StData:   tx_mux = bus.ser_out;
      StParity: tx_mux = parity_q;
      default:  tx_mux = 1'b1;
    endcase
  end

  assign bus.TX_OUT         = tx_mux;
  assign bus.ser_en         = (state_q == StData);
  assign bus.ser_data_valid = accept;
  assign bus.Busy           = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural serializer and a bit-list frame model.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          exp_q[$];
  int unsigned t0;

  uart_tx_ctrl_if #(.WIDTH(8)) bus ();

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sibling serializer: loads on ser_data_valid, shifts LSB first while enabled.
  logic [7:0] sh;
  logic [2:0] cnt;
  always @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (bus.ser_data_valid) begin
      sh  <= bus.P_DATA;
      cnt <= '0;
    end else if (bus.ser_en) begin
      sh  <= sh >> 1;
      cnt <= cnt + 3'd1;
    end else begin
      cnt <= '0;
    end
  end
  assign bus.ser_out  = sh[0];
  assign bus.ser_done = (cnt == 3'd7);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits from START through STOP.
  task automatic build(input logic [7:0] d, input bit pe, input bit pt);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
    if (pe) exp_q.push_back(bit'($countones(d) % 2) ^ pt);
    exp_q.push_back(1'b1);
  endtask

  task automatic accept(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                        input bit hold);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.P_DATA_VLD = 1'b1;
    #1;
    chk({tag, "_acc_sdv"}, bus.ser_data_valid, 1);
    chk({tag, "_acc_busy"}, bus.Busy, 0);
    chk({tag, "_acc_tx"}, bus.TX_OUT, 1);
    chk({tag, "_acc_en"}, bus.ser_en, 0);
    @(negedge clk);
    if (!hold) bus.P_DATA_VLD = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit scramble, input int poke_idx,
                           input int rst_idx);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (scramble) begin
        bus.PAR_EN  = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
        bus.P_DATA  = 8'($urandom);
      end
      if (poke_idx >= 0 && i == poke_idx) begin
        bus.P_DATA     = 8'h3C;
        bus.P_DATA_VLD = 1'b1;
      end else if (poke_idx >= 0 && i == poke_idx + 1) begin
        bus.P_DATA_VLD = 1'b0;
      end
      #1;
      chk($sformatf("%s_tx%0d", tag, i), bus.TX_OUT, exp_q[i]);
      chk($sformatf("%s_busy%0d", tag, i), bus.Busy, 1);
      chk($sformatf("%s_en%0d", tag, i), bus.ser_en, (i >= 1 && i <= 8));
      chk($sformatf("%s_sdv%0d", tag, i), bus.ser_data_valid, 0);
      if (i == rst_idx) begin
        rst            = 1'b1;
        bus.P_DATA_VLD = 1'b1;
        @(negedge clk);
        #1;
        chk({tag, "_rst_tx"}, bus.TX_OUT, 1);
        chk({tag, "_rst_busy"}, bus.Busy, 0);
        chk({tag, "_rst_en"}, bus.ser_en, 0);
        chk({tag, "_rst_sdv"}, bus.ser_data_valid, 0);
        rst            = 1'b0;
        bus.P_DATA_VLD = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    #1;
    chk({tag, "_end_busy"}, bus.Busy, 0);
    chk({tag, "_end_tx"}, bus.TX_OUT, 1);
    chk({tag, "_end_en"}, bus.ser_en, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit         pe;
    bit         pt;

    bus.P_DATA     = 8'h00;
    bus.P_DATA_VLD = 1'b1;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    // Reset with a pending request: nothing may be loaded while RST is high.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sdv", bus.ser_data_valid, 0);
    chk("rst_tx", bus.TX_OUT, 1);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_en", bus.ser_en, 0);
    rst            = 1'b0;
    bus.P_DATA_VLD = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_sdv", bus.ser_data_valid, 0);
    chk("idle_tx", bus.TX_OUT, 1);
    @(negedge clk);

    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    accept("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame("even_a5", 1'b1, -1, -1);

    build(8'h01, 1'b1, 1'b1);
    accept("odd_01", 8'h01, 1'b1, 1'b1, 1'b0);
    run_frame("odd_01", 1'b1, -1, -1);

    build(8'h01, 1'b1, 1'b0);
    accept("even_01", 8'h01, 1'b1, 1'b0, 1'b0);
    run_frame("even_01", 1'b1, -1, -1);

    build(8'hFF, 1'b0, 1'b0);
    accept("nopar_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    run_frame("nopar_ff", 1'b1, -1, -1);

    build(8'h96, 1'b1, 1'b1);
    accept("ignore", 8'h96, 1'b1, 1'b1, 1'b0);
    run_frame("ignore", 1'b0, 3, -1);

    build(8'hC3, 1'b1, 1'b0);
    accept("midrst", 8'hC3, 1'b1, 1'b0, 1'b0);
    run_frame("midrst", 1'b0, -1, 4);

    build(8'h5A, 1'b0, 1'b1);
    accept("after_rst", 8'h5A, 1'b0, 1'b1, 1'b0);
    run_frame("after_rst", 1'b1, -1, -1);

    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      build(d, pe, pt);
      accept($sformatf("rand%0d", k), d, pe, pt, 1'b0);
      run_frame($sformatf("rand%0d", k), 1'b1, (k % 2 == 0) ? int'($urandom_range(1, 7)) : -1,
                -1);
    end

    // Request held high: the second byte is taken on the first IDLE cycle after STOP.
    t0 = cyc;
    accept("b2b_a", 8'h55, 1'b1, 1'b0, 1'b1);
    bus.P_DATA = 8'hAA;
    build(8'h55, 1'b1, 1'b0);
    run_frame("b2b_a", 1'b0, -1, -1);
    chk("b2b_second_sdv", bus.ser_data_valid, 1);
    chk("b2b_period", cyc - t0, 12);
    @(negedge clk);
    bus.P_DATA_VLD = 1'b0;
    build(8'hAA, 1'b1, 1'b0);
    run_frame("b2b_b", 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
